// File: rtl/mode_pkg.sv
// Shared mode definitions for the switch-to-mode decoder: mode codes, the default
// level-to-mode table and the thermometer decoder.
package mode_pkg;

  localparam int MODE_W = 4;

  localparam logic [MODE_W-1:0] MODE_IDLE = 4'd0;
  localparam logic [MODE_W-1:0] MODE_1    = 4'd1;
  localparam logic [MODE_W-1:0] MODE_2    = 4'd2;
  localparam logic [MODE_W-1:0] MODE_3    = 4'd3;
  localparam logic [MODE_W-1:0] MODE_4    = 4'd4;
  localparam logic [MODE_W-1:0] MODE_5    = 4'd5;
  localparam logic [MODE_W-1:0] MODE_6    = 4'd6;

  // Entry k-1 is the mode for level k; level 1 sits in the low nibble.
  localparam logic [6*MODE_W-1:0] DEFAULT_MODE_MAP =
    {MODE_6, MODE_3, MODE_5, MODE_4, MODE_2, MODE_1};

  localparam int MAX_LEVELS = 32;
  localparam int LEVEL_W    = 6;

  typedef struct packed {
    logic               invalid;
    logic [LEVEL_W-1:0] level;
  } level_info_t;

  // Level k means bits [k-1:0] set and everything above clear; any gap is invalid.
  function automatic level_info_t thermo_to_level(input logic [MAX_LEVELS-1:0] bits,
                                                  input int num_levels);
    level_info_t info;
    logic        seen_zero;
    info      = '0;
    seen_zero = 1'b0;
    for (int i = 0; i < MAX_LEVELS; i++) begin
      if (i < num_levels) begin
        if (bits[i]) begin
          if (seen_zero) info.invalid = 1'b1;
          else           info.level   = LEVEL_W'(i + 1);
        end else begin
          seen_zero = 1'b1;
        end
      end
    end
    if (info.invalid) info.level = '0;
    return info;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus level debouncer: a new level commits only after it has
// been seen unchanged for DEBOUNCE_CYCLES consecutive cycles.
module sw_debounce #(
  parameter int WIDTH           = 6,
  parameter int LEVEL_W         = 6,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   raw,
  output logic [WIDTH-1:0]   sync,
  input  logic [LEVEL_W-1:0] level,
  output logic [LEVEL_W-1:0] cand,
  output logic [LEVEL_W-1:0] committed,
  output logic               commit
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [WIDTH-1:0] sync1;
  logic [CNT_W-1:0] cnt;

  // Combinational so the top can register its outputs on the same edge as committed.
  assign commit = (level == cand) && (cand != committed) &&
                  (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  // NOTE: all state here is updated with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      sync      <= '0;
      cand      <= '0;
      committed <= '0;
      cnt       <= '0;
    end else begin
      sync1 <= raw;
      sync  <= sync1;
      if (level != cand) begin
        cand <= level;
        cnt  <= '0;
      end else if (commit) begin
        committed <= cand;
        cnt       <= '0;
      end else if (cand != committed) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mode_select_debounced.sv
// Slide-switch mode selector: debounced thermometer level mapped through MODE_MAP,
// with an active-low one-hot LED indicator and a mode-change strobe.
module mode_select_debounced #(
  parameter int                              SW_WIDTH        = 16,
  parameter int                              NUM_LEVELS      = 6,
  parameter int                              MODE_W          = mode_pkg::MODE_W,
  parameter logic [NUM_LEVELS*MODE_W-1:0]    MODE_MAP        = mode_pkg::DEFAULT_MODE_MAP,
  parameter int                              DEBOUNCE_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SW_WIDTH-1:0] Switch,
  output logic [SW_WIDTH-1:0] Led,
  output logic [MODE_W-1:0]   mode,
  output logic                mode_valid,
  output logic                mode_changed,
  output logic                level_invalid
);

  import mode_pkg::*;

  logic [NUM_LEVELS-1:0] sync2;
  level_info_t           level_info;
  logic [LEVEL_W-1:0]    cand;
  logic [LEVEL_W-1:0]    committed_level;
  logic                  commit;
  logic [MODE_W-1:0]     next_mode;
  logic [SW_WIDTH-1:0]   next_led;

  if (SW_WIDTH > NUM_LEVELS) begin : g_upper
    logic unused_upper;
    assign unused_upper = ^Switch[SW_WIDTH-1:NUM_LEVELS];
  end

  sw_debounce #(
    .WIDTH           (NUM_LEVELS),
    .LEVEL_W         (LEVEL_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .raw       (Switch[NUM_LEVELS-1:0]),
    .sync      (sync2),
    .level     (level_info.level),
    .cand      (cand),
    .committed (committed_level),
    .commit    (commit)
  );

  assign level_info = thermo_to_level(MAX_LEVELS'(sync2), NUM_LEVELS);

  // mode_valid is registered state in effect: committed_level moves on the commit edge.
  assign mode_valid = |committed_level;

  // NOTE: defaults first, so no path through this block leaves a latch behind.
  always_comb begin
    next_mode = '0;
    next_led  = '1;
    for (int k = 1; k <= NUM_LEVELS; k++) begin
      if (int'(cand) == k) begin
        next_mode       = MODE_MAP[k*MODE_W-1 -: MODE_W];
        next_led[k-1]   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Led           <= '1;
      mode          <= '0;
      mode_changed  <= 1'b0;
      level_invalid <= 1'b0;
    end else begin
      level_invalid <= level_info.invalid;
      mode_changed  <= 1'b0;
      if (commit) begin
        mode         <= next_mode;
        Led          <= next_led;
        mode_changed <= (next_mode != mode);
      end
    end
  end

endmodule

// File: tb/tb_mode_select_debounced.sv
// Directed bench for mode_select_debounced with DEBOUNCE_CYCLES=4 (commit on 7th edge).
module tb_mode_select_debounced;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Switch;
  logic [15:0] Led;
  logic [3:0]  mode;
  logic        mode_valid;
  logic        mode_changed;
  logic        level_invalid;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [3:0]  cur_mode;

  mode_select_debounced #(.DEBOUNCE_CYCLES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .Switch        (Switch),
    .Led           (Led),
    .mode          (mode),
    .mode_valid    (mode_valid),
    .mode_changed  (mode_changed),
    .level_invalid (level_invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply sw, expect the commit on the 7th edge, then hold for 10 edges in total.
  task automatic settle(input logic [15:0] sw, input logic [3:0] exp_mode,
                        input logic [15:0] exp_led);
    Switch = sw;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check("hold_mode", 32'(mode), 32'(cur_mode));
      check("hold_strobe", 32'(mode_changed), 32'd0);
    end
    tick();
    check("commit_mode", 32'(mode), 32'(exp_mode));
    check("commit_led", 32'(Led), 32'(exp_led));
    check("commit_valid", 32'(mode_valid), 32'(exp_led != 16'hFFFF));
    check("commit_strobe", 32'(mode_changed), 32'(exp_mode != cur_mode));
    cur_mode = exp_mode;
    tick();
    check("strobe_drop", 32'(mode_changed), 32'd0);
    tick();
    tick();
  endtask

  initial begin
    rst    = 1'b1;
    Switch = 16'h003F;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_led", 32'(Led), 32'hFFFF);
      check("rst_mode", 32'(mode), 32'd0);
      check("rst_valid", 32'(mode_valid), 32'd0);
    end
    check("rst_strobe", 32'(mode_changed), 32'd0);
    check("rst_invalid", 32'(level_invalid), 32'd0);
    rst      = 1'b0;
    cur_mode = 4'd0;
    settle(16'h003F, 4'd6, 16'hFFDF);

    // Sweep through every level
    settle(16'h0001, 4'd1, 16'hFFFE);
    settle(16'h0003, 4'd2, 16'hFFFD);
    settle(16'h0007, 4'd4, 16'hFFFB);
    settle(16'h000F, 4'd5, 16'hFFF7);
    settle(16'h001F, 4'd3, 16'hFFEF);
    settle(16'h003F, 4'd6, 16'hFFDF);

    // Bounce between 0x07 and 0x03 must never commit
    settle(16'h0003, 4'd2, 16'hFFFD);
    for (int i = 0; i < 10; i++) begin
      Switch = (i % 2 == 0) ? 16'h0007 : 16'h0003;
      for (int c = 0; c < 2; c++) begin
        tick();
        check("bounce_mode", 32'(mode), 32'd2);
        check("bounce_strobe", 32'(mode_changed), 32'd0);
      end
    end
    Switch = 16'h0003;
    for (int c = 0; c < 8; c++) begin
      tick();
      check("bounce_back_mode", 32'(mode), 32'd2);
      check("bounce_back_strobe", 32'(mode_changed), 32'd0);
    end
    settle(16'h0007, 4'd4, 16'hFFFB);

    // Non-thermometer pattern falls back to idle
    settle(16'h0003, 4'd2, 16'hFFFD);
    Switch = 16'h0005;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check("inv_flag", 32'(level_invalid), 32'(e >= 3));
      if (e < 7) check("inv_hold_mode", 32'(mode), 32'd2);
    end
    check("inv_mode", 32'(mode), 32'd0);
    check("inv_led", 32'(Led), 32'hFFFF);
    check("inv_valid", 32'(mode_valid), 32'd0);
    check("inv_strobe", 32'(mode_changed), 32'd1);
    cur_mode = 4'd0;
    tick();
    tick();

    // Upper switch bits are ignored
    settle(16'hFF01, 4'd1, 16'hFFFE);
    check("upper_invalid", 32'(level_invalid), 32'd0);

    // Reset in the middle of a pending settle
    Switch = 16'h0003;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst_led", 32'(Led), 32'hFFFF);
    check("midrst_mode", 32'(mode), 32'd0);
    check("midrst_valid", 32'(mode_valid), 32'd0);
    check("midrst_strobe", 32'(mode_changed), 32'd0);
    rst      = 1'b0;
    cur_mode = 4'd0;
    settle(16'h0003, 4'd2, 16'hFFFD);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
